// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for a bus-based datapath. A single FSM walks through
// a common fetch (T0..T2) followed by an opcode-dependent execute phase
// (T3..T6). All strobes are decoded from the current state and the live `ir`
// value; the sequencer never latches `ir`.
//
// Configuration:
//   CTRL_MUL_EN  - when defined, opcode 10000 runs the multiply sequence
//                  (T3..T6). When undefined, that opcode is treated as
//                  undefined, ALU_MUL stays 0 and T6 is never reached.
//
// Ports:
//   clock        - sole clock, all state changes on the rising edge
//   clear        - synchronous active-high reset, highest priority
//   start        - leave IDLE and begin fetching
//   stop         - request halt once the current instruction ends
//   mem_ready    - memory read data valid this cycle
//   ir[31:0]     - instruction: opcode [31:27], Ra [26:23], Rb [22:19],
//                  Rc [18:15]
//   Rin/Rout     - one-hot GPR load / drive strobes
//   PCin..ALU_MUL- single-bit datapath strobes
//   ALUop[3:0]   - ALU operation select (non-zero only in ALU T4)
//   running      - high in every state except IDLE and HALT
//   illegal      - one-cycle pulse in T3 for an undefined opcode
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Yin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        Read,
    output logic        IncPC,
    output logic        ALU_MUL,
    output logic [3:0]  ALUop,
    output logic        running,
    output logic        illegal
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b10001;
    localparam logic [4:0] OP_MFLO = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;

`ifdef CTRL_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    state_t state, next_state;
    logic   stop_seen;   // stop sampled since the current T0
    logic   t1_waited;   // previous cycle was a T1 stalled on memory

    logic [4:0]  opcode;
    logic [15:0] ra_sel, rb_sel, rc_sel;
    logic        is_alu, is_mul;
    logic        unused_ir;

    assign opcode    = ir[31:27];
    assign ra_sel    = 16'h0001 << ir[26:23];
    assign rb_sel    = 16'h0001 << ir[22:19];
    assign rc_sel    = 16'h0001 << ir[18:15];
    assign is_alu    = ~opcode[4];
    assign is_mul    = MUL_EN && (opcode == OP_MUL);
    assign unused_ir = ^ir[14:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the combinational block below uses blocking.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            stop_seen <= 1'b0;
            t1_waited <= 1'b0;
        end else begin
            state     <= next_state;
            stop_seen <= (next_state == T0 || next_state == HALT) ? 1'b0
                                                                    : (stop_seen | stop);
            t1_waited <= (state == T1) && !mem_ready;
        end
    end

    always_comb begin
        state_t end_state;
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        Rin      = '0;
        Rout     = '0;
        PCin     = 1'b0;
        PCout    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        HIin     = 1'b0;
        HIout    = 1'b0;
        LOin     = 1'b0;
        LOout    = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Read     = 1'b0;
        IncPC    = 1'b0;
        ALU_MUL  = 1'b0;
        ALUop    = 4'd0;
        illegal  = 1'b0;
        running  = (state != IDLE) && (state != HALT);
        // A stop seen in the final cycle itself also counts.
        end_state = (stop_seen || stop) ? HALT : T0;

        case (state)
            IDLE: if (start) next_state = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
                next_state = T1;
            end
            T1: begin
                // The incremented PC is written back once, not on every
                // stalled cycle of the memory wait.
                Zlowout = !t1_waited;
                PCin    = !t1_waited;
                Read    = 1'b1;
                MDRin   = mem_ready;
                if (mem_ready) next_state = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                if (is_alu || is_mul) begin
                    Rout = rb_sel; Yin = 1'b1;
                    next_state = T4;
                end else if (opcode == OP_MFHI) begin
                    HIout = 1'b1; Rin = ra_sel;
                    next_state = end_state;
                end else if (opcode == OP_MFLO) begin
                    LOout = 1'b1; Rin = ra_sel;
                    next_state = end_state;
                end else if (opcode == OP_NOP) begin
                    next_state = end_state;
                end else if (opcode == OP_HALT) begin
                    next_state = HALT;
                end else begin
                    illegal    = 1'b1;
                    next_state = end_state;
                end
            end
            T4: begin
                next_state = end_state;
                if (is_alu) begin
                    Rout = rc_sel; ALUop = opcode[3:0];
                    Zlowin = 1'b1; Zhighin = 1'b1;
                    next_state = T5;
                end else if (is_mul) begin
                    Rout = rc_sel; ALU_MUL = 1'b1;
                    Zlowin = 1'b1; Zhighin = 1'b1;
                    next_state = T5;
                end
            end
            T5: begin
                next_state = end_state;
                if (is_alu) begin
                    Zlowout = 1'b1; Rin = ra_sel;
                end else if (is_mul) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                    next_state = T6;
                end
            end
            T6: begin
                if (is_mul) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
                next_state = end_state;
            end
            HALT: begin
                running    = 1'b0;
                next_state = HALT;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Scoreboard bench for control_sequencer. Each scenario task queues per-cycle
// stimulus together with the strobe vector expected for that cycle, then
// replays the queue, comparing the DUT outputs at the falling edge.
// Builds with or without CTRL_MUL_EN; the multiply expectations follow it.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;

    logic [15:0] Rin, Rout;
    logic PCin, PCout, IRin, Yin, MARin, MDRin, MDRout, HIin, HIout, LOin, LOout;
    logic Zlowin, Zhighin, Zlowout, Zhighout, Read, IncPC, ALU_MUL, running, illegal;
    logic [3:0] ALUop;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop),
        .mem_ready(mem_ready), .ir(ir), .Rin(Rin), .Rout(Rout),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin), .HIout(HIout),
        .LOin(LOin), .LOout(LOout), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .Read(Read), .IncPC(IncPC),
        .ALU_MUL(ALU_MUL), .ALUop(ALUop), .running(running), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  aluop;
        logic pcin, pcout, irin, yin, marin, mdrin, mdrout, hiin, hiout;
        logic loin, loout, zlowin, zhighin, zlowout, zhighout, rd, incpc;
        logic alu_mul, running, illegal;
    } outs_t;

    typedef struct packed {
        logic        clr;
        logic        st;
        logic        sp;
        logic        rdy;
        logic [31:0] ir;
    } stim_t;

    outs_t obs;
    assign obs = '{rin: Rin, rout: Rout, aluop: ALUop, pcin: PCin, pcout: PCout,
                   irin: IRin, yin: Yin, marin: MARin, mdrin: MDRin,
                   mdrout: MDRout, hiin: HIin, hiout: HIout, loin: LOin,
                   loout: LOout, zlowin: Zlowin, zhighin: Zhighin,
                   zlowout: Zlowout, zhighout: Zhighout, rd: Read,
                   incpc: IncPC, alu_mul: ALU_MUL, running: running,
                   illegal: illegal};

    stim_t stim_q[$];
    outs_t exp_q[$];
    int    checks = 0;
    int    passes = 0;

    // ---------------- expected-vector builders ----------------
    function automatic logic [15:0] onehot(input int r);
        logic [15:0] v;
        v = 16'h0001 << r;
        return v;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic outs_t e_run();
        outs_t o;
        o = '0;
        o.running = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_t0();
        outs_t o;
        o = e_run();
        o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zlowin = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_t1(input logic first, input logic rdy);
        outs_t o;
        o = e_run();
        o.zlowout = first; o.pcin = first; o.rd = 1'b1; o.mdrin = rdy;
        return o;
    endfunction

    function automatic outs_t e_t2();
        outs_t o;
        o = e_run();
        o.mdrout = 1'b1; o.irin = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_t3_rb(input int rb);
        outs_t o;
        o = e_run();
        o.rout = onehot(rb); o.yin = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_t4_alu(input int rc, input logic [3:0] op);
        outs_t o;
        o = e_run();
        o.rout = onehot(rc); o.aluop = op; o.zlowin = 1'b1; o.zhighin = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_t5_alu(input int ra);
        outs_t o;
        o = e_run();
        o.zlowout = 1'b1; o.rin = onehot(ra);
        return o;
    endfunction

    function automatic outs_t e_mov(input logic hi, input int ra);
        outs_t o;
        o = e_run();
        o.hiout = hi; o.loout = !hi; o.rin = onehot(ra);
        return o;
    endfunction

    function automatic outs_t e_ill();
        outs_t o;
        o = e_run();
        o.illegal = 1'b1;
        return o;
    endfunction

`ifdef CTRL_MUL_EN
    function automatic outs_t e_t4_mul(input int rc);
        outs_t o;
        o = e_run();
        o.rout = onehot(rc); o.alu_mul = 1'b1; o.zlowin = 1'b1; o.zhighin = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_t5_mul();
        outs_t o;
        o = e_run();
        o.zlowout = 1'b1; o.loin = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_t6_mul();
        outs_t o;
        o = e_run();
        o.zhighout = 1'b1; o.hiin = 1'b1;
        return o;
    endfunction
`endif

    // ---------------- stimulus plumbing ----------------
    function automatic stim_t st(input logic c, input logic s, input logic p,
                                 input logic r, input logic [31:0] i);
        stim_t v;
        v.clr = c; v.st = s; v.sp = p; v.rdy = r; v.ir = i;
        return v;
    endfunction

    task automatic push(input stim_t s, input outs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the
    // falling edge where that cycle's outputs are stable.
    task automatic apply(input stim_t s);
        @(posedge clock);
        #1;
        clear = s.clr; start = s.st; stop = s.sp; mem_ready = s.rdy; ir = s.ir;
        @(negedge clock);
    endtask

    task automatic do_clear();
        apply(st(1, 0, 0, 0, 32'd0));
    endtask

    // Queue start-from-IDLE plus a zero-wait fetch of instruction i.
    task automatic push_fetch(input logic [31:0] i);
        push(st(0, 1, 0, 1, i), '0);
        push(st(0, 0, 0, 1, i), e_t0());
        push(st(0, 0, 0, 1, i), e_t1(1, 1));
        push(st(0, 0, 0, 1, i), e_t2());
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t s; outs_t e; int n;
        n = 0;
        do_clear();
        push(st(1, 1, 0, 1, 32'hFFFF_FFFF), '0);
        push(st(0, 0, 0, 1, 32'd0), '0);
        push(st(0, 0, 1, 0, 32'd0), '0);
        push(st(0, 0, 0, 0, 32'd0), '0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL reset cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    task automatic test_alu();
        stim_t s; outs_t e; int n;
        logic [31:0] i1, i2;
        n = 0;
        i1 = 32'h0088_0000;
        i2 = mk_ir(5'b00101, 4'd7, 4'd3, 4'd12);
        do_clear();
        push_fetch(i1);
        push(st(0, 0, 0, 1, i1), e_t3_rb(1));
        push(st(0, 0, 0, 1, i1), e_t4_alu(0, 4'd0));
        push(st(0, 0, 0, 1, i1), e_t5_alu(1));
        // back-to-back: next instruction fetched without revisiting IDLE
        push(st(0, 0, 0, 1, i2), e_t0());
        push(st(0, 0, 0, 1, i2), e_t1(1, 1));
        push(st(0, 0, 0, 1, i2), e_t2());
        push(st(0, 0, 0, 1, i2), e_t3_rb(3));
        push(st(0, 0, 0, 1, i2), e_t4_alu(12, 4'd5));
        push(st(0, 0, 0, 1, i2), e_t5_alu(7));
        push(st(0, 0, 0, 1, i2), e_t0());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL alu cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s; outs_t e; int n;
        logic [31:0] i;
        n = 0;
        i = mk_ir(5'b11110, 4'd0, 4'd0, 4'd0);
        do_clear();
        push(st(0, 1, 0, 0, i), '0);
        push(st(0, 0, 0, 0, i), e_t0());
        push(st(0, 0, 0, 0, i), e_t1(1, 0));
        push(st(0, 0, 0, 0, i), e_t1(0, 0));
        push(st(0, 0, 0, 0, i), e_t1(0, 0));
        push(st(0, 0, 0, 1, i), e_t1(0, 1));
        push(st(0, 0, 0, 1, i), e_t2());
        push(st(0, 0, 0, 1, i), e_run());
        push(st(0, 0, 0, 1, i), e_t0());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL mem_wait cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    task automatic test_move();
        stim_t s; outs_t e; int n;
        logic [31:0] hi, lo;
        n = 0;
        hi = mk_ir(5'b10001, 4'd5, 4'd0, 4'd0);
        lo = mk_ir(5'b10010, 4'd9, 4'd0, 4'd0);
        do_clear();
        push_fetch(hi);
        push(st(0, 0, 0, 1, hi), e_mov(1, 5));
        push(st(0, 0, 0, 1, lo), e_t0());
        push(st(0, 0, 0, 1, lo), e_t1(1, 1));
        push(st(0, 0, 0, 1, lo), e_t2());
        push(st(0, 0, 0, 1, lo), e_mov(0, 9));
        push(st(0, 0, 0, 1, lo), e_t0());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL move cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    task automatic test_mul();
        stim_t s; outs_t e; int n;
        logic [31:0] i;
        n = 0;
        i = mk_ir(5'b10000, 4'd2, 4'd3, 4'd4);
        do_clear();
        push_fetch(i);
`ifdef CTRL_MUL_EN
        push(st(0, 0, 0, 1, i), e_t3_rb(3));
        push(st(0, 0, 0, 1, i), e_t4_mul(4));
        push(st(0, 0, 0, 1, i), e_t5_mul());
        push(st(0, 0, 0, 1, i), e_t6_mul());
`else
        push(st(0, 0, 0, 1, i), e_ill());
`endif
        push(st(0, 0, 0, 1, i), e_t0());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL mul cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    task automatic test_illegal();
        stim_t s; outs_t e; int n;
        logic [31:0] i;
        n = 0;
        i = mk_ir(5'b10111, 4'd6, 4'd6, 4'd6);
        do_clear();
        push_fetch(i);
        push(st(0, 0, 0, 1, i), e_ill());
        push(st(0, 0, 0, 1, i), e_t0());
        push(st(0, 0, 0, 1, i), e_t1(1, 1));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL illegal cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    task automatic test_stop_halt();
        stim_t s; outs_t e; int n;
        logic [31:0] i1, hlt;
        n = 0;
        i1  = 32'h0088_0000;
        hlt = mk_ir(5'b11111, 4'd0, 4'd0, 4'd0);
        do_clear();
        // stop pulsed in T1: instruction completes, then HALT
        push(st(0, 1, 0, 1, i1), '0);
        push(st(0, 0, 0, 1, i1), e_t0());
        push(st(0, 0, 1, 1, i1), e_t1(1, 1));
        push(st(0, 0, 0, 1, i1), e_t2());
        push(st(0, 0, 0, 1, i1), e_t3_rb(1));
        push(st(0, 0, 0, 1, i1), e_t4_alu(0, 4'd0));
        push(st(0, 0, 0, 1, i1), e_t5_alu(1));
        push(st(0, 1, 0, 1, i1), '0);
        push(st(0, 1, 0, 1, i1), '0);
        push(st(1, 1, 0, 1, i1), '0);
        // halt opcode goes straight to HALT from T3
        push(st(0, 1, 0, 1, hlt), '0);
        push(st(0, 0, 0, 1, hlt), e_t0());
        push(st(0, 0, 0, 1, hlt), e_t1(1, 1));
        push(st(0, 0, 0, 1, hlt), e_t2());
        push(st(0, 0, 0, 1, hlt), e_run());
        push(st(0, 1, 0, 1, hlt), '0);
        push(st(0, 0, 0, 1, hlt), '0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL stop_halt cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    task automatic test_clear_mid();
        stim_t s; outs_t e; int n;
        logic [31:0] i, i1;
        n = 0;
        i1 = 32'h0088_0000;
`ifdef CTRL_MUL_EN
        i = mk_ir(5'b10000, 4'd2, 4'd3, 4'd4);
`else
        i = i1;
`endif
        do_clear();
        push_fetch(i);
`ifdef CTRL_MUL_EN
        push(st(0, 0, 0, 1, i), e_t3_rb(3));
        push(st(1, 0, 1, 1, i), e_t4_mul(4));
`else
        push(st(0, 0, 0, 1, i), e_t3_rb(1));
        push(st(1, 0, 1, 1, i), e_t4_alu(0, 4'd0));
`endif
        push(st(0, 0, 0, 1, i), '0);
        push(st(0, 1, 0, 0, i1), '0);
        push(st(0, 0, 0, 0, i1), e_t0());
        // stop then clear during a memory wait: the stop must be forgotten
        push(st(0, 0, 1, 0, i1), e_t1(1, 0));
        push(st(1, 0, 0, 0, i1), e_t1(0, 0));
        push(st(0, 1, 0, 1, i1), '0);
        push(st(0, 0, 0, 1, i1), e_t0());
        push(st(0, 0, 0, 1, i1), e_t1(1, 1));
        push(st(0, 0, 0, 1, i1), e_t2());
        push(st(0, 0, 0, 1, i1), e_t3_rb(1));
        push(st(0, 0, 0, 1, i1), e_t4_alu(0, 4'd0));
        push(st(0, 0, 0, 1, i1), e_t5_alu(1));
        push(st(0, 0, 0, 1, i1), e_t0());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s); checks++;
            if (obs !== e) $display("FAIL clear_mid cycle %0d: got %h expected %h", n, obs, e);
            else passes++;
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_move();
        test_mul();
        test_illegal();
        test_stop_halt();
        test_clear_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port clear, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, in IDLE, begin fetching at next edge.
REQ-004 SHALL have port stop, input, 1, request halt after current instruction.
REQ-005 SHALL have port mem_ready, input, 1, memory read data valid this cycle.
REQ-006 SHALL have port ir, input, 32, IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-007 SHALL have port Rin / Rout, output, 16 each, GPR load/drive strobes, at most one bit set.
REQ-008 SHALL have ports PCin, PCout, IRin, Yin, MARin, MDRin, MDRout, HIin, HIout, LOin, LOout, Zlowin, Zhighin, Zlowout, Zhighout, Read, IncPC, ALU_MUL, output, 1 each, datapath strobes.
REQ-009 SHALL have port ALUop, output, 4, ALU operation select.
REQ-010 SHALL have port running, output, 1, high outside IDLE/HALT.
REQ-011 SHALL have port illegal, output, 1, one-cycle pulse on undefined opcode.

Function
REQ-012 SHALL implement states IDLE, T0..T6, HALT; all outputs combinational from state and ir (Moore-plus-decode), at most one bus driver asserted per cycle.
REQ-013 IDLE: start=1 -> T0; else stay.
REQ-014 T0: PCout, MARin, IncPC, Zlowin -> T1.
REQ-015 T1: Zlowout, PCin only on first T1 cycle; Read every T1 cycle; MDRin only in cycle with mem_ready=1; advance to T2 only when mem_ready=1 (unbounded wait).
REQ-016 T2: MDRout, IRin -> T3.
REQ-017 Opcode 0xxxx (ALU): T3 Rout[Rb], Yin; T4 Rout[Rc], ALUop=opcode[3:0], Zlowin, Zhighin; T5 Zlowout, Rin[Ra]; end.
REQ-018 Opcode 10000 (mul): T3 Rout[Rb], Yin; T4 Rout[Rc], ALU_MUL, Zlowin, Zhighin; T5 Zlowout, LOin; T6 Zhighout, HIin; end.
REQ-019 Opcode 10001 (mfhi): T3 HIout, Rin[Ra]; end. 10010 (mflo): T3 LOout, Rin[Ra]; end.
REQ-020 Opcode 11110 (nop): T3 no strobes; end. 11111 (halt): T3 -> HALT.
REQ-021 Any other opcode: T3 no strobes, illegal=1 for that cycle; end.
REQ-022 "end" SHALL go to T0, or to HALT if stop was sampled high in any cycle since the current T0 (sticky flag, cleared on entering T0/HALT).
REQ-023 HALT: all strobes 0, running=0; stays until clear; start ignored.
REQ-024 ALUop SHALL be 0 and ALU_MUL 0 in every state except REQ-017/REQ-018 T4.
REQ-025 Ra/Rb/Rc SHALL be decoded from ir as presented each cycle; sequencer does not latch ir.

Reset
REQ-026 clear=1 at any edge, including mid-instruction or mid memory wait, SHALL force IDLE, clear stop flag; all outputs 0 the following cycle.
REQ-027 clear SHALL take priority over start, stop and mem_ready.

Configuration
REQ-028 Macro CTRL_MUL_EN defined: opcode 10000 follows REQ-018.
REQ-029 CTRL_MUL_EN undefined: opcode 10000 treated per REQ-021 (illegal pulse, no strobes), ALU_MUL tied 0, state T6 unreachable.

Verification
REQ-030 clear, start pulse, mem_ready=1 always, ir=0x0088_0000 (add R1,R1,R0 shape) -> T0..T5 in 6 cycles; T5 Rin=0x0002, Zlowout=1; next T0.
REQ-031 Fetch with mem_ready low 3 cycles -> Read high 4 cycles, MDRin high only on 4th, PCin high only on first T1 cycle.
REQ-032 ir opcode 10000, Ra=2,Rb=3,Rc=4 (CTRL_MUL_EN) -> T3 Rout=0x0008; T4 Rout=0x0010, ALU_MUL=1; T5 LOin; T6 HIin; 7 cycles total.
REQ-033 ir opcode 10111 -> illegal=1 exactly one cycle in T3, no Rin/HIin/LOin, returns to T0.
REQ-034 stop pulsed during T1 of ALU instruction -> instruction completes through T5, then HALT, running=0; later start has no effect.
REQ-035 clear asserted during T4 of mul -> next cycle IDLE, all outputs 0; start restarts at T0.
